// File: rtl/reaction_ctrl.sv
// Reaction-time game sequencer: random pre-stimulus delay, stimulus LED,
// millisecond reaction measurement with false-start and timeout detection.
module reaction_ctrl #(
   parameter int unsigned CLK_PER_MS    = 50000,
   parameter int unsigned MIN_DELAY_MS  = 1000,
   parameter int unsigned DELAY_STEP_MS = 8,
   parameter int unsigned MAX_RT_MS     = 9999
) (
   input  logic        clk,
   input  logic        res,
   input  logic        start,
   input  logic        react,
   input  logic [7:0]  lfsr_out,
   output logic        lfsr_en,
   output logic        lfsr_stop,
   output logic        lfsr_res,
   output logic        led,
   output logic [13:0] rt_ms,
   output logic        rt_valid,
   output logic        early,
   output logic        timeout,
   output logic        busy
);

   localparam int unsigned PW = $clog2(CLK_PER_MS);

   localparam logic [PW-1:0] PrescLast = PW'(CLK_PER_MS - 1);
   localparam logic [15:0]   MinDelay  = 16'(MIN_DELAY_MS);
   localparam logic [15:0]   DelayStep = 16'(DELAY_STEP_MS);
   localparam logic [13:0]   MaxRt     = 14'(MAX_RT_MS);

   typedef enum logic [2:0] {
      StIdle,
      StArm,
      StSnap,
      StWait,
      StGo,
      StDone,
      StFault
   } state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   delay_q, delay_d;
   logic [13:0]   rt_cnt_q, rt_cnt_d;
   logic [13:0]   rt_ms_q, rt_ms_d;
   logic          rt_valid_q, rt_valid_d;
   logic          early_q, early_d;
   logic          timeout_q, timeout_d;
   logic          start_q, start_p_q;
   logic          react_q, react_p_q;
   logic          lfsr_res_q, lfsr_en_q;

   logic          tick;
   logic [13:0]   rt_inc;
   logic [13:0]   rt_now;

   assign tick   = (presc_q == PrescLast);
   assign rt_inc = (rt_cnt_q >= MaxRt) ? MaxRt : rt_cnt_q + 14'd1;
   // Counter value as of this edge, so a tick coinciding with react is counted
   assign rt_now = tick ? rt_inc : rt_cnt_q;

   // Next-state and datapath updates
   always_comb begin
      state_d    = state_q;
      delay_d    = delay_q;
      rt_cnt_d   = rt_cnt_q;
      rt_ms_d    = rt_ms_q;
      rt_valid_d = 1'b0;
      early_d    = early_q;
      timeout_d  = timeout_q;
      unique case (state_q)
         StIdle, StDone, StFault: begin
            if (start_p_q) begin
               state_d   = StArm;
               early_d   = 1'b0;
               timeout_d = 1'b0;
               rt_ms_d   = 14'd0;
            end
         end
         StArm: begin
            state_d = StSnap;
         end
         StSnap: begin
            delay_d = MinDelay + 16'(lfsr_out) * DelayStep;
            state_d = StWait;
         end
         StWait: begin
            if (react_p_q) begin
               state_d = StFault;
               early_d = 1'b1;
            end else if (tick) begin
               if (delay_q <= 16'd1) begin
                  state_d  = StGo;
                  rt_cnt_d = 14'd0;
               end else begin
                  delay_d = delay_q - 16'd1;
               end
            end
         end
         StGo: begin
            rt_cnt_d = rt_now;
            if (react_p_q) begin
               state_d    = StDone;
               rt_ms_d    = rt_now;
               rt_valid_d = 1'b1;
            end else if (tick && (rt_inc == MaxRt)) begin
               state_d   = StDone;
               timeout_d = 1'b1;
               rt_ms_d   = MaxRt;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Prescaler restarts on every state entry
      if (state_d != state_q || tick) begin
         presc_d = '0;
      end else begin
         presc_d = presc_q + PW'(1);
      end
   end

   // State, datapath and edge-detect registers with synchronous reset
   always_ff @(posedge clk) begin
      if (res) begin
         state_q    <= StIdle;
         presc_q    <= '0;
         delay_q    <= 16'd0;
         rt_cnt_q   <= 14'd0;
         rt_ms_q    <= 14'd0;
         rt_valid_q <= 1'b0;
         early_q    <= 1'b0;
         timeout_q  <= 1'b0;
         // Track the buttons so a press held through reset gives no edge
         start_q    <= start;
         react_q    <= react;
         start_p_q  <= 1'b0;
         react_p_q  <= 1'b0;
         lfsr_res_q <= 1'b1;
         lfsr_en_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         delay_q    <= delay_d;
         rt_cnt_q   <= rt_cnt_d;
         rt_ms_q    <= rt_ms_d;
         rt_valid_q <= rt_valid_d;
         early_q    <= early_d;
         timeout_q  <= timeout_d;
         start_q    <= start;
         react_q    <= react;
         start_p_q  <= start & ~start_q;
         react_p_q  <= react & ~react_q;
         lfsr_res_q <= 1'b0;
         lfsr_en_q  <= 1'b1;
      end
   end

   assign lfsr_en   = lfsr_en_q;
   assign lfsr_res  = lfsr_res_q;
   assign lfsr_stop = (state_q == StArm);
   assign led       = (state_q == StGo);
   assign rt_ms     = rt_ms_q;
   assign rt_valid  = rt_valid_q;
   assign early     = early_q;
   assign timeout   = timeout_q;
   assign busy      = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed self-checking bench for reaction_ctrl with a fast millisecond tick.
module tb_reaction_ctrl;

   localparam int unsigned CPM  = 4;
   localparam int unsigned MIND = 10;
   localparam int unsigned STEP = 1;
   localparam int unsigned MAXR = 20;

   logic        clk = 1'b0;
   logic        res;
   logic        start;
   logic        react;
   logic [7:0]  lfsr_out;
   logic        lfsr_en;
   logic        lfsr_stop;
   logic        lfsr_res;
   logic        led;
   logic [13:0] rt_ms;
   logic        rt_valid;
   logic        early;
   logic        timeout;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   reaction_ctrl #(
      .CLK_PER_MS   (CPM),
      .MIN_DELAY_MS (MIND),
      .DELAY_STEP_MS(STEP),
      .MAX_RT_MS    (MAXR)
   ) dut (
      .clk      (clk),
      .res      (res),
      .start    (start),
      .react    (react),
      .lfsr_out (lfsr_out),
      .lfsr_en  (lfsr_en),
      .lfsr_stop(lfsr_stop),
      .lfsr_res (lfsr_res),
      .led      (led),
      .rt_ms    (rt_ms),
      .rt_valid (rt_valid),
      .early    (early),
      .timeout  (timeout),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expectation
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n clock edges, leaving time 1 unit past the last edge
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Start a round; returns just after the edge entering WAIT
   task automatic begin_round(input string tag);
      start = 1'b1;
      step(2);
      check_eq({tag, "_stop"}, 32'(lfsr_stop), 32'd1);
      check_eq({tag, "_early_clr"}, 32'(early), 32'd0);
      start = 1'b0;
      step(2);
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
   endtask

   int cnt;

   initial begin
      res      = 1'b1;
      start    = 1'b1;
      react    = 1'b1;
      lfsr_out = 8'h05;

      // Reset with both buttons held
      step(2);
      check_eq("rst_lfsr_res", 32'(lfsr_res), 32'd1);
      check_eq("rst_lfsr_en", 32'(lfsr_en), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_led", 32'(led), 32'd0);
      check_eq("rst_rt_ms", 32'(rt_ms), 32'd0);
      check_eq("rst_flags", {29'd0, rt_valid, early, timeout}, 32'd0);
      check_eq("rst_stop", 32'(lfsr_stop), 32'd0);
      res = 1'b0;
      step(1);
      check_eq("rel_lfsr_res", 32'(lfsr_res), 32'd0);
      check_eq("rel_lfsr_en", 32'(lfsr_en), 32'd1);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         cnt += int'(lfsr_stop) + int'(busy);
      end
      check_eq("rel_no_arm", 32'(cnt), 32'd0);
      start = 1'b0;
      react = 1'b0;
      step(2);

      // Normal round: delay (10+5) ms = 60 cycles, react 30 cycles in -> 7 ms
      begin_round("n");
      step(59);
      check_eq("n_led_before", 32'(led), 32'd0);
      step(1);
      check_eq("n_led_rise", 32'(led), 32'd1);
      step(28);
      react = 1'b1;
      step(1);
      check_eq("n_valid_early", 32'(rt_valid), 32'd0);
      step(1);
      check_eq("n_valid", 32'(rt_valid), 32'd1);
      check_eq("n_rt_ms", 32'(rt_ms), 32'd7);
      check_eq("n_led_off", 32'(led), 32'd0);
      check_eq("n_busy_off", 32'(busy), 32'd0);
      step(1);
      check_eq("n_valid_pulse", 32'(rt_valid), 32'd0);
      check_eq("n_rt_hold", 32'(rt_ms), 32'd7);
      react = 1'b0;
      step(2);

      // False start three cycles into WAIT
      begin_round("f");
      step(1);
      react = 1'b1;
      step(2);
      check_eq("f_early", 32'(early), 32'd1);
      check_eq("f_fault_busy", 32'(busy), 32'd1);
      react = 1'b0;
      cnt = 0;
      for (int i = 0; i < 70; i++) begin
         step(1);
         cnt += int'(led);
      end
      check_eq("f_no_led", 32'(cnt), 32'd0);

      // React edge coinciding with WAIT expiry -> false start wins
      begin_round("tw");
      step(58);
      react = 1'b1;
      step(2);
      check_eq("tw_early", 32'(early), 32'd1);
      check_eq("tw_led", 32'(led), 32'd0);
      react = 1'b0;
      step(2);

      // Timeout after 80 cycles in GO
      begin_round("to");
      step(60);
      check_eq("to_led", 32'(led), 32'd1);
      cnt = 0;
      for (int i = 0; i < 79; i++) begin
         step(1);
         cnt += int'(rt_valid) + int'(timeout);
      end
      check_eq("to_not_yet", 32'(cnt), 32'd0);
      step(1);
      check_eq("to_timeout", 32'(timeout), 32'd1);
      check_eq("to_rt_ms", 32'(rt_ms), 32'(MAXR));
      check_eq("to_led_off", 32'(led), 32'd0);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         cnt += int'(rt_valid);
      end
      check_eq("to_no_valid", 32'(cnt), 32'd0);

      // React edge coinciding with the timeout tick -> valid reaction wins
      begin_round("tg");
      check_eq("tg_timeout_clr", 32'(timeout), 32'd0);
      step(60);
      step(78);
      react = 1'b1;
      step(2);
      check_eq("tg_valid", 32'(rt_valid), 32'd1);
      check_eq("tg_rt_ms", 32'(rt_ms), 32'(MAXR));
      check_eq("tg_timeout", 32'(timeout), 32'd0);
      react = 1'b0;
      step(2);

      // Start edges during WAIT and GO are ignored
      begin_round("ig");
      step(10);
      start = 1'b1;
      step(2);
      start = 1'b0;
      check_eq("ig_wait_stop", 32'(lfsr_stop), 32'd0);
      step(48);
      check_eq("ig_led", 32'(led), 32'd1);
      start = 1'b1;
      step(2);
      check_eq("ig_go_led", 32'(led), 32'd1);
      check_eq("ig_go_stop", 32'(lfsr_stop), 32'd0);
      start = 1'b0;
      react = 1'b1;
      step(2);
      check_eq("ig_valid", 32'(rt_valid), 32'd1);
      check_eq("ig_rt_ms", 32'(rt_ms), 32'd1);
      react = 1'b0;
      step(1);

      // Restart from DONE, then reset mid-GO
      begin_round("mr");
      check_eq("mr_rt_clr", 32'(rt_ms), 32'd0);
      step(60);
      check_eq("mr_led", 32'(led), 32'd1);
      res = 1'b1;
      step(1);
      check_eq("mr_led_off", 32'(led), 32'd0);
      check_eq("mr_idle", 32'(busy), 32'd0);
      check_eq("mr_rt_ms", 32'(rt_ms), 32'd0);
      check_eq("mr_lfsr_res", 32'(lfsr_res), 32'd1);
      res = 1'b0;
      step(1);
      check_eq("mr_lfsr_res_rel", 32'(lfsr_res), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
